uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Transmit path of the UART, directly downstream of the AXI-Lite register block.
//  Buffers bytes pushed as single-cycle tx_byte/tx_valid pulses in a FIFO.
//  Serializes each byte onto uart_txd as 8N/8E/8O frames with 1/2/3 stop bits.
//  Reports FIFO empty/full/fill back to the register block.
// PARAMETERS
//  FIFO_DEPTH  16  TX FIFO entries; power of 2, >=2
// PORTS
//  clk             in   1   clock
//  reset_n         in   1   async active-low reset
//  cr_pbit         in   1   parity enable
//  cr_ptype        in   1   parity type: 0 even, 1 odd
//  cr_sbit         in   2   stop bits: 00->1, 01->2, 10/11->3
//  cr_baud_limit   in   32  bit period = cr_baud_limit+1 clocks
//  cr_baud_update  in   1   1-clk pulse: baud limit rewritten
//  cr_tx_en        in   1   transmitter enable
//  tx_byte         in   8   byte to enqueue
//  tx_valid        in   1   1-clk enqueue strobe; no backpressure
//  fifo_tx_empty   out  1   FIFO empty
//  fifo_tx_full    out  1   FIFO full
//  fifo_tx_fill    out  32  FIFO occupancy, zero-extended
//  uart_txd        out  1   serial line, idle high
//  tx_busy         out  1   frame in progress (state != IDLE)
//  cts_n           in   1   clear-to-send, active low; present only with UART_TX_CTS_EN
// BEHAVIOUR
//  Reset: FIFO emptied, fifo_tx_empty=1, fifo_tx_full=0, fifo_tx_fill=0, uart_txd=1, tx_busy=0, state IDLE.
//   Reset takes effect immediately, including mid-frame.
//  FIFO push: write when tx_valid && (!full || pop this cycle).
//   tx_valid while full with no pop: byte dropped silently; fill, pointers and full unchanged.
//   Simultaneous push+pop: fill unchanged. Flags and fill are registered, valid the cycle after an edge.
//  Baud counter: cleared in IDLE and on cr_baud_update.
//   Otherwise counts 0..cr_baud_limit, then wraps to 0. tick = (cnt==cr_baud_limit).
//   cr_baud_limit=0: tick every clock.
//   Update mid-frame: current bit restarts with the new limit; the frame is not aborted.
//  FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE:
//   IDLE: pop when cr_tx_en && !fifo_tx_empty (&& cts ok). Pop loads the shift register and latches
//    cr_pbit/cr_ptype/cr_sbit for the whole frame, then -> START.
//    Latency: tx_valid into an empty FIFO at cycle N -> uart_txd low from cycle N+2.
//   START: txd=0 until tick -> DATA, bit index 0.
//   DATA: txd=data[idx], LSB first, one bit per tick. After idx 7: -> PARITY if pbit, else -> STOP.
//   PARITY: txd = ^data ^ ptype, i.e. even -> total ones even.
//   STOP: txd=1 for 1/2/3 bit periods per latched sbit, then -> IDLE.
//   Back-to-back frames have exactly 1 clk of IDLE (txd=1) between the last stop bit and the next start bit.
//  cr_tx_en cleared mid-frame: the current frame completes and no new pop occurs. The FIFO still accepts pushes.
//  Config changes mid-frame do not affect the frame in flight.
// CONFIGURATION
//  UART_TX_CTS_EN defined:
//   - cts_n port exists and passes through a 2-flop synchronizer.
//   - IDLE pops only when synchronized cts_n==0.
//   - cts_n rising mid-frame does not abort the frame.
//  UART_TX_CTS_EN undefined:
//   - cts_n port absent.
//   - The pop condition ignores CTS.
// TESTING
//  1. limit=3+update, pbit=0, sbit=00, push 0x55 -> txd 0,1,0,1,0,1,0,1,0,1, each 4 clk; tx_busy 40 clk; empty=1 after pop.
//  2. pbit=1, ptype=0, push 0x07 -> parity bit 1. ptype=1 -> 0. sbit=10 -> stop high 12 clk at limit=3.
//  3. tx_en=0, push 17 bytes 0x00..0x10 -> full=1, fill=16, 0x10 dropped. tx_en=1 -> 16 frames 0x00..0x0F in order, 1-clk gaps.
//  4. Clear tx_en during DATA bit 3 with fill=2 -> frame completes, txd stays 1, fill stays 1. Re-enable -> next frame starts.
//  5. Assert reset_n during DATA bit 5 with fill=4 -> txd=1, tx_busy=0, empty=1, fill=0 immediately.
//  6. UART_TX_CTS_EN, cts_n=1, push 0xA5 -> no start. Drop cts_n -> start bit within 4 clk.
//     Raise cts_n mid-frame -> frame completes.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmit path.
//
// Bytes arrive as single-cycle tx_byte/tx_valid strobes and are buffered in a
// FIFO_DEPTH-entry FIFO. Each byte is sent on uart_txd as a frame:
// one start bit (low), 8 data bits LSB first, an optional even/odd parity bit,
// and 1, 2 or 3 stop bits (high). Each bit lasts cr_baud_limit+1 clocks.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   cr_pbit/cr_ptype   parity enable / type (0 even, 1 odd)
//   cr_sbit            stop bits: 00->1, 01->2, 10/11->3
//   cr_baud_limit      bit period minus one, in clocks
//   cr_baud_update     pulse: restart the current bit with the new limit
//   cr_tx_en           allow new frames to start
//   tx_byte/tx_valid   enqueue strobe; dropped silently when full
//   fifo_tx_*          FIFO empty / full / occupancy (registered)
//   uart_txd           serial line, idle high (registered)
//   tx_busy            a frame is in progress
//   cts_n              clear-to-send, active low (only with UART_TX_CTS_EN)
//
// Build option: define UART_TX_CTS_EN to add the cts_n input. It is
// synchronised with two flops and gates the start of each new frame only.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cr_pbit,
  input  logic        cr_ptype,
  input  logic [1:0]  cr_sbit,
  input  logic [31:0] cr_baud_limit,
  input  logic        cr_baud_update,
  input  logic        cr_tx_en,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        fifo_tx_empty,
  output logic        fifo_tx_full,
  output logic [31:0] fifo_tx_fill,
  output logic        uart_txd,
  output logic        tx_busy
`ifdef UART_TX_CTS_EN
  ,
  input  logic        cts_n
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------------------------------------------------------- FIFO ----
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          empty_q, full_q;
  logic          push, pop;
  logic [7:0]    rd_data;

  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    fill_d   = fill_q;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push     = tx_valid && (!full_q || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    if (push && !pop)      fill_d = fill_q + CNT_ONE;
    else if (pop && !push) fill_d = fill_q - CNT_ONE;
  end

  // NOTE: the storage array has no reset; only pointers and fill define
  // which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_byte;
  end

  // ------------------------------------------------------------ CTS gate ----
  logic cts_ok;
`ifdef UART_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;
  // Reset to "not clear" so nothing starts before the line is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end
  assign cts_ok = !cts_sync_q;
`else
  assign cts_ok = 1'b1;
`endif

  // ------------------------------------------------------ serializer FSM ----
  state_e      state_q, state_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic [1:0]  sbit_q, sbit_d;
  logic        txd_q, txd_d;
  logic        tick;
  logic [2:0]  stop_last;

  // An update pulse clears the counter, so it suppresses the tick too.
  assign tick      = (state_q != S_IDLE) && !cr_baud_update &&
                     (baud_cnt_q == cr_baud_limit);
  assign stop_last = (sbit_q == 2'b00) ? 3'd0 :
                     (sbit_q == 2'b01) ? 3'd1 : 3'd2;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    sbit_d    = sbit_q;
    pop       = 1'b0;

    if (state_q == S_IDLE || cr_baud_update || tick) baud_cnt_d = '0;
    else                                             baud_cnt_d = baud_cnt_q + 32'd1;

    unique case (state_q)
      S_IDLE: begin
        if (cr_tx_en && !empty_q && cts_ok) begin
          // Frame format is captured here and held for the whole frame.
          pop       = 1'b1;
          data_d    = rd_data;
          par_en_d  = cr_pbit;
          par_bit_d = ^rd_data ^ cr_ptype;
          sbit_d    = cr_sbit;
          idx_d     = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          idx_d   = 3'd0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // idx_q counts stop bits already completed.
        if (tick) begin
          if (idx_q == stop_last) state_d = S_IDLE;
          else                    idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so uart_txd is a clean flop.
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[idx_d];
      S_PARITY: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      sbit_q     <= '0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      sbit_q     <= sbit_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      empty_q    <= (fill_d == '0);
      full_q     <= (fill_d == CNT_FULL);
    end
  end

  assign fifo_tx_empty = empty_q;
  assign fifo_tx_full  = full_q;
  assign fifo_tx_fill  = {{(31-AW){1'b0}}, fill_q};
  assign uart_txd      = txd_q;
  assign tx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Expected line waveforms come from a frame model that lists the bit levels
// of a frame and stretches each to cr_baud_limit+1 clocks.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cr_pbit, cr_ptype;
  logic [1:0]  cr_sbit;
  logic [31:0] cr_baud_limit;
  logic        cr_baud_update, cr_tx_en;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        fifo_tx_empty, fifo_tx_full;
  logic [31:0] fifo_tx_fill;
  logic        uart_txd, tx_busy;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(.FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cr_pbit        (cr_pbit),
    .cr_ptype       (cr_ptype),
    .cr_sbit        (cr_sbit),
    .cr_baud_limit  (cr_baud_limit),
    .cr_baud_update (cr_baud_update),
    .cr_tx_en       (cr_tx_en),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .fifo_tx_empty  (fifo_tx_empty),
    .fifo_tx_full   (fifo_tx_full),
    .fifo_tx_fill   (fifo_tx_fill),
    .uart_txd       (uart_txd),
    .tx_busy        (tx_busy)
`ifdef UART_TX_CTS_EN
    ,
    .cts_n          (cts_n)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: sample k of the returned vector is the line level k clocks
  // after the start bit begins; the final sample is the idle level.
  function automatic void model(input logic [7:0] b, input logic pbit, input logic ptype,
                                input logic [1:0] sbit, input int limit,
                                output logic [255:0] wav, output int len);
    int bits[$];
    int n_stop;
    int k;
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(b[i]));
    if (pbit) bits.push_back(($countones(b) + int'(ptype)) % 2);
    n_stop = (sbit == 2'b00) ? 1 : (sbit == 2'b01) ? 2 : 3;
    for (int i = 0; i < n_stop; i++) bits.push_back(1);
    wav = '0;
    k = 0;
    foreach (bits[j]) begin
      for (int r = 0; r <= limit; r++) begin
        wav[k] = (bits[j] != 0);
        k++;
      end
    end
    wav[k] = 1'b1;
    len = k;
  endfunction

  task automatic set_cfg(input logic pbit, input logic ptype, input logic [1:0] sbit, input int limit);
    @(negedge clk);
    cr_pbit = pbit; cr_ptype = ptype; cr_sbit = sbit;
    cr_baud_limit = 32'(limit);
    cr_baud_update = 1'b1;
    @(negedge clk);
    cr_baud_update = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then records len+1 samples.
  // act at sample act_at: 1 = clear tx_en, 2 = scramble format, 3 = raise cts_n.
  task automatic capture(input string tag, input int budget, input int len,
                         input int act_at, input int act,
                         output logic [255:0] wav, output logic [255:0] bsy, output int waited);
    wav = '0; bsy = '0; waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (uart_txd !== 1'b0 && waited < budget);
    if (uart_txd !== 1'b0) begin
      check({tag, "_start_timeout"}, 256'(uart_txd), 256'd0);
      return;
    end
    for (int i = 0; i <= len; i++) begin
      if (i > 0) @(negedge clk);
      wav[i] = uart_txd;
      bsy[i] = tx_busy;
      if (i == act_at) begin
        case (act)
          1: cr_tx_en = 1'b0;
          2: begin
            cr_pbit  = 1'($urandom);
            cr_ptype = 1'($urandom);
            cr_sbit  = 2'($urandom);
          end
`ifdef UART_TX_CTS_EN
          3: cts_n = 1'b1;
`endif
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic pbit,
                             input logic ptype, input logic [1:0] sbit, input int limit,
                             input int budget, input int act_at, input int act,
                             output int waited);
    logic [255:0] ew, eb, ow, ob;
    int len;
    model(b, pbit, ptype, sbit, limit, ew, len);
    eb = '0;
    for (int i = 0; i < len; i++) eb[i] = 1'b1;
    capture(tag, budget, len, act_at, act, ow, ob, waited);
    check({tag, "_txd"}, ow, ew);
    check({tag, "_busy"}, ob, eb);
  endtask

  // Watches the idle line for n clocks; returns 1 if txd or busy ever moved.
  task automatic idle_watch(input int n, output logic moved);
    moved = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) moved = 1'b1;
    end
  endtask

  initial begin
    logic [255:0] ow, ob;
    logic         moved;
    int           w;
    logic [7:0]   rb;
    logic         rp, rt;
    logic [1:0]   rs;
    int           rl;

    reset_n = 1'b0;
    cr_pbit = 1'b0; cr_ptype = 1'b0; cr_sbit = 2'b00;
    cr_baud_limit = 32'd3; cr_baud_update = 1'b0; cr_tx_en = 1'b0;
    tx_byte = 8'h00; tx_valid = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd",   256'(uart_txd),      256'd1);
    check("rst_busy",  256'(tx_busy),       256'd0);
    check("rst_empty", 256'(fifo_tx_empty), 256'd1);
    check("rst_full",  256'(fifo_tx_full),  256'd0);
    check("rst_fill",  256'(fifo_tx_fill),  256'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x55, 8N1, 4-clock bits; start bit two cycles after the push
    cr_tx_en = 1'b1;
    set_cfg(1'b0, 1'b0, 2'b00, 3);
    push(8'h55);
    check("t1_fill_after_push", 256'(fifo_tx_fill), 256'd1);
    check("t1_txd_before_start", 256'(uart_txd), 256'd1);
    check_frame("t1", 8'h55, 1'b0, 1'b0, 2'b00, 3, 8, -1, 0, w);
    check("t1_latency", 256'(w), 256'd1);
    check("t1_empty", 256'(fifo_tx_empty), 256'd1);

    // Parity even/odd and three stop bits
    set_cfg(1'b1, 1'b0, 2'b00, 3);
    push(8'h07);
    check_frame("t2_even", 8'h07, 1'b1, 1'b0, 2'b00, 3, 8, -1, 0, w);
    set_cfg(1'b1, 1'b1, 2'b10, 3);
    push(8'h07);
    check_frame("t2_odd_3stop", 8'h07, 1'b1, 1'b1, 2'b10, 3, 8, -1, 0, w);

    // Fill to full with transmitter disabled; 17th byte is dropped
    set_cfg(1'b0, 1'b0, 2'b00, 3);
    cr_tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      tx_byte = 8'(i); tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("t3_full",  256'(fifo_tx_full),  256'd1);
    check("t3_fill",  256'(fifo_tx_fill),  256'd16);
    check("t3_empty", 256'(fifo_tx_empty), 256'd0);
    cr_tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_frame($sformatf("t3_f%0d", i), 8'(i), 1'b0, 1'b0, 2'b00, 3, 10, -1, 0, w);
      check($sformatf("t3_gap%0d", i), 256'(w), 256'd1);
    end
    idle_watch(30, moved);
    check("t3_no_extra_frame", 256'(moved), 256'd0);
    check("t3_empty_end", 256'(fifo_tx_empty), 256'd1);
    check("t3_fill_end",  256'(fifo_tx_fill),  256'd0);

    // Disable during DATA bit 3: frame finishes, nothing new starts
    cr_tx_en = 1'b0;
    push(8'hA1);
    push(8'hB2);
    check("t4_fill_pre", 256'(fifo_tx_fill), 256'd2);
    cr_tx_en = 1'b1;
    check_frame("t4_f0", 8'hA1, 1'b0, 1'b0, 2'b00, 3, 10, 16, 1, w);
    idle_watch(40, moved);
    check("t4_held_idle", 256'(moved), 256'd0);
    check("t4_fill_held", 256'(fifo_tx_fill), 256'd1);
    cr_tx_en = 1'b1;
    check_frame("t4_f1", 8'hB2, 1'b0, 1'b0, 2'b00, 3, 10, -1, 0, w);

    // Reset during DATA bit 5 with four bytes queued
    cr_tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    cr_tx_en = 1'b1;
    capture("t5", 10, 0, -1, 0, ow, ob, w);
    repeat (25) @(negedge clk);
    check("t5_fill_pre", 256'(fifo_tx_fill), 256'd4);
    check("t5_busy_pre", 256'(tx_busy), 256'd1);
    reset_n = 1'b0;
    #1;
    check("t5_txd",   256'(uart_txd),      256'd1);
    check("t5_busy",  256'(tx_busy),       256'd0);
    check("t5_empty", 256'(fifo_tx_empty), 256'd1);
    check("t5_fill",  256'(fifo_tx_fill),  256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_watch(20, moved);
    check("t5_quiet_after", 256'(moved), 256'd0);

    // Random formats; format inputs scrambled mid-frame must not matter
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      rp = 1'($urandom);
      rt = 1'($urandom);
      rs = 2'($urandom);
      rl = (k == 0) ? 0 : int'($urandom_range(0, 7));
      set_cfg(rp, rt, rs, rl);
      push(rb);
      check_frame($sformatf("rnd%0d", k), rb, rp, rt, rs, rl, 8, 3, 2, w);
    end

`ifdef UART_TX_CTS_EN
    // CTS gating: held off while cts_n high, frame survives cts_n rising
    set_cfg(1'b0, 1'b0, 2'b00, 3);
    @(negedge clk);
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    push(8'hA5);
    idle_watch(20, moved);
    check("cts_held_off", 256'(moved), 256'd0);
    check("cts_fill", 256'(fifo_tx_fill), 256'd1);
    cts_n = 1'b0;
    check_frame("cts_frame", 8'hA5, 1'b0, 1'b0, 2'b00, 3, 4, 10, 3, w);
    check("cts_start_within_4", 256'(w <= 4), 256'd1);
    cts_n = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
